// File: rtl/adat_pkg.sv
// rtl/adat_pkg.sv - shared frame constants and state type for the ADAT transmit path
package adat_pkg;

   localparam int FRAME_BITS = 256;
   localparam int BIT_IDX_W  = 8;

   typedef enum logic {
      HUNT,
      RECEIVE
   } tdm_state_t;

   function automatic logic is_last_bit(input logic [BIT_IDX_W-1:0] cnt);
      return cnt == BIT_IDX_W'(FRAME_BITS - 1);
   endfunction

endpackage

// File: rtl/input_synchronizer.sv
// rtl/input_synchronizer.sv - multi-stage flip-flop synchronizer for one asynchronous input
module input_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_chain <= '0;
      end else begin
         r_chain[0] <= i_d;
         for (int k = 1; k < STAGES; k++) begin
            r_chain[k] <= r_chain[k-1];
         end
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/tdm_frame_writer.sv
// rtl/tdm_frame_writer.sv - deserializes 256-bit TDM frames into circular channel_buffer slots
module tdm_frame_writer
   import adat_pkg::*;
#(
   parameter int CIRC_BUF_BITS  = 3,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           tdm_bclk_i,
   input  logic                           tdm_fsync_i,
   input  logic                           tdm_data_i,
   output logic [CIRC_BUF_BITS+BIT_IDX_W-1:0] ram_write_addr_o,
   output logic                           ram_write_data_o,
   output logic                           ram_wr_en_o,
   output logic [CIRC_BUF_BITS-1:0]       last_good_frame_idx_o,
   output logic                           locked_o,
   output logic                           frame_err_o
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic w_bclk_s, w_fsync_s, w_data_s, w_edge;
   logic r_bclk_prev;

   tdm_state_t               r_state, w_state_nxt;
   logic [BIT_IDX_W-1:0]     r_bit_cnt, w_cnt_nxt, w_addr_cnt;
   logic [CIRC_BUF_BITS-1:0] r_wr_frame, w_frame_nxt;
   logic [WD_W-1:0]          r_watchdog, w_wd_nxt;
   logic                     w_we, w_err, w_done, w_locked_nxt;

   input_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_bclk (
      .i_clk(clk_i), .i_rst(rst_i), .i_d(tdm_bclk_i), .o_q(w_bclk_s)
   );
   input_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_fsync (
      .i_clk(clk_i), .i_rst(rst_i), .i_d(tdm_fsync_i), .o_q(w_fsync_s)
   );
   input_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_data (
      .i_clk(clk_i), .i_rst(rst_i), .i_d(tdm_data_i), .o_q(w_data_s)
   );

   assign w_edge = w_bclk_s & ~r_bclk_prev;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_bit_cnt;
      w_addr_cnt   = r_bit_cnt;
      w_frame_nxt  = r_wr_frame;
      w_wd_nxt     = r_watchdog;
      w_locked_nxt = locked_o;
      w_we         = 1'b0;
      w_err        = 1'b0;
      w_done       = 1'b0;
      if (w_edge) begin
         w_wd_nxt = '0;
         if (w_fsync_s) begin
            // Early sync restarts the same slot; the partial frame is simply overwritten.
            w_we        = 1'b1;
            w_addr_cnt  = '0;
            w_cnt_nxt   = BIT_IDX_W'(1);
            w_err       = (r_state == RECEIVE) && (r_bit_cnt != '0);
            w_state_nxt = RECEIVE;
         end else if (r_state == RECEIVE) begin
            if (r_bit_cnt == '0) begin
               w_err        = 1'b1;
               w_state_nxt  = HUNT;
               w_locked_nxt = 1'b0;
            end else begin
               w_we      = 1'b1;
               w_cnt_nxt = r_bit_cnt + BIT_IDX_W'(1);
               if (is_last_bit(r_bit_cnt)) begin
                  w_done       = 1'b1;
                  w_frame_nxt  = r_wr_frame + CIRC_BUF_BITS'(1);
                  w_locked_nxt = 1'b1;
               end
            end
         end
      end else if (r_state == RECEIVE) begin
         if (r_watchdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
            w_err        = 1'b1;
            w_state_nxt  = HUNT;
            w_locked_nxt = 1'b0;
            w_cnt_nxt    = '0;
            w_wd_nxt     = '0;
         end else begin
            w_wd_nxt = r_watchdog + WD_W'(1);
         end
      end else begin
         w_wd_nxt = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state               <= HUNT;
         r_bclk_prev           <= 1'b0;
         r_bit_cnt             <= '0;
         r_wr_frame            <= '0;
         r_watchdog            <= '0;
         ram_write_addr_o      <= '0;
         ram_write_data_o      <= 1'b0;
         ram_wr_en_o           <= 1'b0;
         last_good_frame_idx_o <= '0;
         locked_o              <= 1'b0;
         frame_err_o           <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_bclk_prev      <= w_bclk_s;
         r_bit_cnt        <= w_cnt_nxt;
         r_wr_frame       <= w_frame_nxt;
         r_watchdog       <= w_wd_nxt;
         ram_write_addr_o <= {r_wr_frame, w_addr_cnt};
         ram_write_data_o <= w_data_s;
         ram_wr_en_o      <= w_we;
         frame_err_o      <= w_err;
         locked_o         <= w_locked_nxt;
         if (w_done) begin
            last_good_frame_idx_o <= r_wr_frame;
         end
      end
   end

endmodule

// File: tb/tb_tdm_frame_writer.sv
// tb/tb_tdm_frame_writer.sv - scoreboard bench for tdm_frame_writer
module tb_tdm_frame_writer;

   localparam int HALF = 4;

   typedef struct {
      logic [10:0] addr;
      logic        data;
      logic [2:0]  lg;
      logic        lk;
   } exp_t;

   logic        clk, rst, bclk, fsync, data;
   logic [10:0] ram_write_addr_o;
   logic        ram_write_data_o, ram_wr_en_o, locked_o, frame_err_o;
   logic [2:0]  last_good_frame_idx_o;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   err_seen = 0;

   tdm_frame_writer #(
      .CIRC_BUF_BITS(3), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .tdm_bclk_i(bclk), .tdm_fsync_i(fsync), .tdm_data_i(data),
      .ram_write_addr_o(ram_write_addr_o), .ram_write_data_o(ram_write_data_o),
      .ram_wr_en_o(ram_wr_en_o), .last_good_frame_idx_o(last_good_frame_idx_o),
      .locked_o(locked_o), .frame_err_o(frame_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (frame_err_o) err_seen++;
         if (ram_wr_en_o) begin
            chk("strobe_pending", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("wr_addr", 32'(ram_write_addr_o), 32'(e.addr));
               chk("wr_data", 32'(ram_write_data_o), 32'(e.data));
               chk("last_good", 32'(last_good_frame_idx_o), 32'(e.lg));
               chk("locked", 32'(locked_o), 32'(e.lk));
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL global_timeout actual=running expected=finished");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   task automatic send_bit(input logic fs, input logic d, input logic push,
                           input logic [10:0] a, input logic [2:0] lg, input logic lk);
      exp_t e;
      @(negedge clk);
      bclk = 1'b0; fsync = fs; data = d;
      if (push) begin
         e.addr = a; e.data = d; e.lg = lg; e.lk = lk;
         q.push_back(e);
      end
      repeat (HALF) @(negedge clk);
      bclk = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic send_frame(input int slot, input logic [31:0] w, input logic [2:0] lg0,
                             input logic lk0, input int nbits);
      logic [2:0]  s;
      logic [7:0]  bi;
      logic        last;
      s = slot[2:0];
      for (int i = 0; i < nbits; i++) begin
         bi   = i[7:0];
         last = (i == 255);
         send_bit(i == 0, w[31 - (i % 32)], 1'b1, {s, bi}, last ? s : lg0, last ? 1'b1 : lk0);
      end
   endtask

   task automatic drain(input string name);
      repeat (8) @(negedge clk);
      chk(name, 32'(q.size()), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; bclk = 1'b0; fsync = 1'b0; data = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_en", 32'(ram_wr_en_o), 32'd0);
      chk("rst_addr", 32'(ram_write_addr_o), 32'd0);
      chk("rst_lg", 32'(last_good_frame_idx_o), 32'd0);
      chk("rst_lock", 32'(locked_o), 32'd0);
      chk("rst_err", 32'(frame_err_o), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   logic [31:0] words [9];
   int e0;

   initial begin
      rst = 1'b1; bclk = 1'b0; fsync = 1'b0; data = 1'b0;
      words[0] = 32'hA5A5A5A5; words[1] = 32'h0F0F0F0F; words[2] = 32'h12345678;
      words[3] = 32'hDEADBEEF; words[4] = 32'h80000001; words[5] = 32'h7FFFFFFE;
      words[6] = 32'hCAFEF00D; words[7] = 32'h00FF00FF; words[8] = 32'h3C3CC3C3;

      // clean frames, slot wrap 7 -> 0
      do_reset();
      e0 = err_seen;
      for (int f = 0; f < 9; f++) begin
         send_frame(f % 8, words[f], (f == 0) ? 3'd0 : 3'((f - 1) % 8), f != 0, 256);
         if (f == 0) begin
            repeat (6) @(negedge clk);
            chk("t1_locked_after_f0", 32'(locked_o), 32'd1);
         end
         if (f == 7) begin
            repeat (6) @(negedge clk);
            chk("t2_lg_7", 32'(last_good_frame_idx_o), 32'd7);
         end
      end
      drain("t2_drain");
      chk("t2_lg_0", 32'(last_good_frame_idx_o), 32'd0);
      chk("t2_no_err", 32'(err_seen - e0), 32'd0);

      // early fsync at bit 100 of frame 2
      do_reset();
      e0 = err_seen;
      send_frame(0, words[0], 3'd0, 1'b0, 256);
      send_frame(1, words[1], 3'd0, 1'b1, 256);
      send_frame(2, words[2], 3'd1, 1'b1, 100);
      send_frame(2, words[3], 3'd1, 1'b1, 1);
      repeat (6) @(negedge clk);
      chk("t3_err_once", 32'(err_seen - e0), 32'd1);
      chk("t3_lg_held", 32'(last_good_frame_idx_o), 32'd1);
      for (int i = 1; i < 256; i++) begin
         send_bit(1'b0, words[3][31 - (i % 32)], 1'b1, {3'd2, i[7:0]},
                  (i == 255) ? 3'd2 : 3'd1, 1'b1);
      end
      drain("t3_drain");
      chk("t3_lg_2", 32'(last_good_frame_idx_o), 32'd2);

      // missing fsync after frame 0
      do_reset();
      e0 = err_seen;
      send_frame(0, words[0], 3'd0, 1'b0, 256);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 1'b0, 11'd0, 3'd0, 1'b0);
      repeat (6) @(negedge clk);
      chk("t4_err", 32'(err_seen - e0), 32'd1);
      chk("t4_unlocked", 32'(locked_o), 32'd0);
      chk("t4_lg_held", 32'(last_good_frame_idx_o), 32'd0);
      send_frame(1, words[2], 3'd0, 1'b0, 256);
      drain("t4_drain");
      chk("t4_lg_1", 32'(last_good_frame_idx_o), 32'd1);

      // bclk stall mid-frame
      do_reset();
      e0 = err_seen;
      send_frame(0, words[0], 3'd0, 1'b0, 256);
      send_frame(1, words[1], 3'd0, 1'b1, 50);
      repeat (100) @(negedge clk);
      chk("t5_err", 32'(err_seen - e0), 32'd1);
      chk("t5_unlocked", 32'(locked_o), 32'd0);
      send_frame(1, words[4], 3'd0, 1'b0, 256);
      drain("t5_drain");
      chk("t5_err_still_one", 32'(err_seen - e0), 32'd1);
      chk("t5_lg_1", 32'(last_good_frame_idx_o), 32'd1);

      // async reset while bit 37's strobe is in flight
      do_reset();
      send_frame(0, words[2], 3'd0, 1'b0, 37);
      @(negedge clk);
      bclk = 1'b0; fsync = 1'b0; data = 1'b1;
      repeat (HALF) @(negedge clk);
      bclk = 1'b1;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_en_zero", 32'(ram_wr_en_o), 32'd0);
      chk("t6_addr_zero", 32'(ram_write_addr_o), 32'd0);
      chk("t6_lg_zero", 32'(last_good_frame_idx_o), 32'd0);
      chk("t6_lock_zero", 32'(locked_o), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("t6_no_stale", 32'(q.size()), 32'd0);
      send_frame(0, words[1], 3'd0, 1'b0, 256);
      drain("t6_drain");
      chk("t6_locked", 32'(locked_o), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
